// File: rtl/sd_rx_pkg.sv
// rtl/sd_rx_pkg.sv - shared types and constants for the SD 4-bit receive data path
package sd_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      END,
      FINISH
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam int          CRC_LEN    = 16;

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - serial CRC16 (x^16+x^12+x^5+1), init 0, one bit per enabled cycle
module sd_crc16
   import sd_rx_pkg::*;
(
   input  logic        wclk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic fb;

   assign fb = bit_i ^ crc_o[15];

   always_ff @(posedge wclk or posedge rst) begin
      if (rst)
         crc_o <= '0;
      else if (clr)
         crc_o <= '0;
      else if (en)
         crc_o <= {crc_o[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   end

endmodule

// File: rtl/sd_rx_data_ctrl.sv
// rtl/sd_rx_data_ctrl.sv - SD DAT[3:0] receive sequencer: start bit, payload to FIFO, per-line CRC16, end bit
module sd_rx_data_ctrl
   import sd_rx_pkg::*;
#(
   parameter int          BLKSZ_W  = 12,
   parameter int          BLKCNT_W = 16,
   parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
   input  logic                wclk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [BLKSZ_W-1:0]  blk_size,
   input  logic [BLKCNT_W-1:0] blk_cnt,
   input  logic [3:0]          dat_i,
   input  logic                fifo_full,
   output logic [3:0]          fifo_d,
   output logic                fifo_wr,
   output logic                busy,
   output logic                done,
   output logic [BLKCNT_W-1:0] blks_rcvd,
   output logic                crc_err,
   output logic                end_err,
   output logic                ovf_err,
   output logic                to_err
);

   state_t                state, next_state;
   logic [BLKSZ_W-1:0]    blk_size_q;
   logic [BLKCNT_W-1:0]   blk_cnt_q;
   logic [BLKSZ_W:0]      nib_cnt;
   logic [BLKSZ_W:0]      nib_last;
   logic [3:0]            bit_cnt;
   logic [15:0]           to_cnt;
   logic [15:0]           crc_q [4];
   logic                  crc_mis;
   logic                  end_bad;
   logic                  blk_last;
   logic                  accept;
   logic                  next_done;
   logic                  wr_now;

   assign busy     = (state != IDLE);
   assign nib_last = {blk_size_q, 1'b0} - (BLKSZ_W+1)'(1);
   assign end_bad  = (dat_i != 4'hF);
   assign blk_last = ((blks_rcvd + BLKCNT_W'(1)) == blk_cnt_q);
   assign wr_now   = (state == DATA) && !fifo_full && !abort;

   for (genvar k = 0; k < 4; k++) begin : g_crc
      sd_crc16 u_crc (
         .wclk  (wclk),
         .rst   (rst),
         .clr   (state == WAIT_START),
         .en    (state == DATA),
         .bit_i (dat_i[k]),
         .crc_o (crc_q[k])
      );
   end

   // CRC is sent MSB first, so cycle n of the CRC phase carries bit 15-n (= ~bit_cnt)
   always_comb begin
      crc_mis = 1'b0;
      for (int k = 0; k < 4; k++)
         if (dat_i[k] != crc_q[k][~bit_cnt])
            crc_mis = 1'b1;
   end

   always_ff @(posedge wclk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      next_done  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE:
            if (start) begin
               if (blk_cnt != '0) begin
                  accept     = 1'b1;
                  next_state = WAIT_START;
               end else begin
                  next_done  = 1'b1;
               end
            end
         WAIT_START:
            if (dat_i == 4'h0)
               next_state = DATA;
            else if (to_cnt == TIMEOUT)
               next_state = FINISH;
         DATA:
            if (nib_cnt == nib_last)
               next_state = CRC;
         CRC:
            if (bit_cnt == 4'(CRC_LEN-1))
               next_state = END;
         END:
            if (blk_last || end_bad || crc_err || end_err || ovf_err || to_err)
               next_state = FINISH;
            else
               next_state = WAIT_START;
         FINISH: begin
            next_state = IDLE;
            next_done  = 1'b1;
         end
         default:
            next_state = IDLE;
      endcase
      if (abort) begin
         next_state = IDLE;
         next_done  = 1'b0;
         accept     = 1'b0;
      end
   end

   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         blk_size_q <= '0;
         blk_cnt_q  <= '0;
         nib_cnt    <= '0;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         fifo_d     <= '0;
         fifo_wr    <= 1'b0;
         done       <= 1'b0;
         blks_rcvd  <= '0;
         crc_err    <= 1'b0;
         end_err    <= 1'b0;
         ovf_err    <= 1'b0;
         to_err     <= 1'b0;
      end else begin
         fifo_wr <= wr_now;
         done    <= next_done;
         if (wr_now)
            fifo_d <= dat_i;
         to_cnt <= (state == WAIT_START) ? to_cnt + 16'd1 : 16'd0;
         if (accept) begin
            blk_size_q <= blk_size;
            blk_cnt_q  <= blk_cnt;
            blks_rcvd  <= '0;
            crc_err    <= 1'b0;
            end_err    <= 1'b0;
            ovf_err    <= 1'b0;
            to_err     <= 1'b0;
         end
         case (state)
            WAIT_START: begin
               nib_cnt <= '0;
               bit_cnt <= '0;
               if (dat_i != 4'h0 && to_cnt == TIMEOUT)
                  to_err <= 1'b1;
            end
            DATA: begin
               nib_cnt <= nib_cnt + (BLKSZ_W+1)'(1);
               if (fifo_full)
                  ovf_err <= 1'b1;
            end
            CRC: begin
               bit_cnt <= bit_cnt + 4'd1;
               if (crc_mis)
                  crc_err <= 1'b1;
            end
            END: begin
               blks_rcvd <= blks_rcvd + BLKCNT_W'(1);
               if (end_bad)
                  end_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
